// File: rtl/mshr_ctrl.sv
// mshr_ctrl: miss-status holding table sequencing victim writebacks and line reads to L2, matching responses into fills
module mshr_ctrl #(
   parameter int N_MSHR = 4,
   parameter int ADDR_W = 26,
   parameter int ID_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic [3:0]        alloc_way,
   input  logic              alloc_rwitm,
   input  logic              alloc_wb,
   input  logic [ADDR_W-1:0] alloc_victim_addr,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              mshr_hit,
   output logic              l2_req_valid,
   input  logic              l2_req_ready,
   output logic [2:0]        l2_req_op,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic [ID_W-1:0]   l2_req_id,
   input  logic              l2_rsp_valid,
   input  logic [ID_W-1:0]   l2_rsp_id,
   output logic              fill_valid,
   output logic [3:0]        fill_way,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              fill_rwitm,
   output logic              protocol_err
);
   typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, WAIT_FILL, FILL} state_e;
   state_e            state_q  [N_MSHR];
   state_e            state_d  [N_MSHR];
   logic [ADDR_W-1:0] addr_q   [N_MSHR];
   logic [ADDR_W-1:0] addr_d   [N_MSHR];
   logic [ADDR_W-1:0] victim_q [N_MSHR];
   logic [ADDR_W-1:0] victim_d [N_MSHR];
   logic [3:0]        way_q    [N_MSHR];
   logic [3:0]        way_d    [N_MSHR];
   logic              rwitm_q  [N_MSHR];
   logic              rwitm_d  [N_MSHR];
   logic              lock_q, lock_d;
   logic [ID_W-1:0]   sel_q, sel_d, sel, alloc_idx, pend_idx;
   logic              fill_valid_q, fill_valid_d, fill_rwitm_q, fill_rwitm_d;
   logic [3:0]        fill_way_q, fill_way_d;
   logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
   logic              protocol_err_q, protocol_err_d;
   logic              accept, pend_any, hs, rsp_ok, tbl_alloc_hit;
   always_comb begin
      alloc_ready   = 1'b0;
      alloc_idx     = '0;
      pend_any      = 1'b0;
      pend_idx      = '0;
      mshr_hit      = 1'b0;
      tbl_alloc_hit = 1'b0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         if (state_q[i] == IDLE) begin
            alloc_ready = 1'b1;
            alloc_idx   = ID_W'(i);
         end
         if (state_q[i] == WB_REQ || state_q[i] == RD_REQ) begin
            pend_any = 1'b1;
            pend_idx = ID_W'(i);
         end
         if (state_q[i] != IDLE && addr_q[i] == lookup_addr) mshr_hit = 1'b1;
         if (state_q[i] != IDLE && addr_q[i] == alloc_addr) tbl_alloc_hit = 1'b1;
      end
      accept   = alloc_valid && alloc_ready;
      mshr_hit = mshr_hit || (accept && alloc_addr == lookup_addr);
      // a stalled request keeps its entry so lower-index arrivals cannot displace it
      sel          = lock_q ? sel_q : pend_idx;
      l2_req_valid = lock_q || pend_any;
      hs           = l2_req_valid && l2_req_ready;
      lock_d       = l2_req_valid && !l2_req_ready;
      sel_d        = sel;
      l2_req_id    = l2_req_valid ? sel : '0;
      l2_req_op    = !l2_req_valid ? 3'd0 : state_q[sel] == WB_REQ ? 3'd4 : rwitm_q[sel] ? 3'd7 : 3'd3;
      l2_req_addr  = !l2_req_valid ? '0 : state_q[sel] == WB_REQ ? victim_q[sel] : addr_q[sel];
      rsp_ok         = l2_rsp_valid && state_q[l2_rsp_id] == WAIT_FILL;
      protocol_err_d = protocol_err_q || (l2_rsp_valid && !rsp_ok);
      fill_valid_d   = rsp_ok;
      fill_way_d     = rsp_ok ? way_q[l2_rsp_id] : 4'd0;
      fill_addr_d    = rsp_ok ? addr_q[l2_rsp_id] : '0;
      fill_rwitm_d   = rsp_ok && rwitm_q[l2_rsp_id];
      state_d  = state_q;
      addr_d   = addr_q;
      victim_d = victim_q;
      way_d    = way_q;
      rwitm_d  = rwitm_q;
      for (int i = 0; i < N_MSHR; i++) begin
         case (state_q[i])
            IDLE: if (accept && alloc_idx == ID_W'(i)) begin
               state_d[i]  = alloc_wb ? WB_REQ : RD_REQ;
               addr_d[i]   = alloc_addr;
               victim_d[i] = alloc_victim_addr;
               way_d[i]    = alloc_way;
               rwitm_d[i]  = alloc_rwitm;
            end
            WB_REQ:    if (hs && sel == ID_W'(i)) state_d[i] = RD_REQ;
            RD_REQ:    if (hs && sel == ID_W'(i)) state_d[i] = WAIT_FILL;
            WAIT_FILL: if (rsp_ok && l2_rsp_id == ID_W'(i)) state_d[i] = FILL;
            default:   state_d[i] = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= '{default: IDLE};
         addr_q         <= '{default: '0};
         victim_q       <= '{default: '0};
         way_q          <= '{default: '0};
         rwitm_q        <= '{default: 1'b0};
         lock_q         <= 1'b0;
         sel_q          <= '0;
         fill_valid_q   <= 1'b0;
         fill_way_q     <= '0;
         fill_addr_q    <= '0;
         fill_rwitm_q   <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         victim_q       <= victim_d;
         way_q          <= way_d;
         rwitm_q        <= rwitm_d;
         lock_q         <= lock_d;
         sel_q          <= sel_d;
         fill_valid_q   <= fill_valid_d;
         fill_way_q     <= fill_way_d;
         fill_addr_q    <= fill_addr_d;
         fill_rwitm_q   <= fill_rwitm_d;
         protocol_err_q <= protocol_err_d;
      end
   end
   assign fill_valid   = fill_valid_q;
   assign fill_way     = fill_way_q;
   assign fill_addr    = fill_addr_q;
   assign fill_rwitm   = fill_rwitm_q;
   assign protocol_err = protocol_err_q;
   a_no_dup_alloc: assert property (@(posedge clk) disable iff (rst) !(accept && tbl_alloc_hit));
endmodule

// File: tb/tb_mshr_ctrl.sv
// tb_mshr_ctrl: directed checks of allocation, L2 request sequencing, fills and reset
module tb_mshr_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_valid = 1'b0, alloc_ready, alloc_rwitm = 1'b0, alloc_wb = 1'b0;
   logic [25:0] alloc_addr = '0, alloc_victim_addr = '0, lookup_addr = '0;
   logic [3:0]  alloc_way = '0;
   logic        mshr_hit, l2_req_valid, l2_req_ready = 1'b1, l2_rsp_valid = 1'b0;
   logic [2:0]  l2_req_op;
   logic [25:0] l2_req_addr, fill_addr;
   logic [1:0]  l2_req_id, l2_rsp_id = '0;
   logic        fill_valid, fill_rwitm, protocol_err;
   logic [3:0]  fill_way;
   int n_cmp = 0, n_err = 0;
   mshr_ctrl dut (
      .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
      .alloc_way(alloc_way), .alloc_rwitm(alloc_rwitm), .alloc_wb(alloc_wb), .alloc_victim_addr(alloc_victim_addr),
      .lookup_addr(lookup_addr), .mshr_hit(mshr_hit), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
      .l2_req_op(l2_req_op), .l2_req_addr(l2_req_addr), .l2_req_id(l2_req_id), .l2_rsp_valid(l2_rsp_valid),
      .l2_rsp_id(l2_rsp_id), .fill_valid(fill_valid), .fill_way(fill_way), .fill_addr(fill_addr),
      .fill_rwitm(fill_rwitm), .protocol_err(protocol_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic alloc(input logic [25:0] a, input logic [3:0] w, input logic rw, input logic wb, input logic [25:0] v);
      alloc_valid = 1'b1;
      alloc_addr = a;
      alloc_way = w;
      alloc_rwitm = rw;
      alloc_wb = wb;
      alloc_victim_addr = v;
      #1;
   endtask
   task automatic req(input string tag, input logic [2:0] op, input logic [25:0] a, input logic [1:0] id);
      chk({tag, "_valid"}, l2_req_valid, 1);
      chk({tag, "_op"}, l2_req_op, op);
      chk({tag, "_addr"}, l2_req_addr, a);
      chk({tag, "_id"}, l2_req_id, id);
   endtask
   task automatic fill(input string tag, input logic [3:0] w, input logic [25:0] a, input logic rw);
      chk({tag, "_valid"}, fill_valid, 1);
      chk({tag, "_way"}, fill_way, w);
      chk({tag, "_addr"}, fill_addr, a);
      chk({tag, "_rwitm"}, fill_rwitm, rw);
   endtask
   task automatic rsp(input logic [1:0] id);
      l2_rsp_valid = 1'b1;
      l2_rsp_id = id;
      tick();
      l2_rsp_valid = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready", alloc_ready, 1);
      chk("rst_req", l2_req_valid, 0);
      chk("rst_fill", fill_valid, 0);
      chk("rst_perr", protocol_err, 0);
      chk("rst_hit", mshr_hit, 0);
      // clean load miss
      lookup_addr = 26'h100;
      alloc(26'h100, 4'b0010, 1'b0, 1'b0, 26'h0);
      chk("t1_hit_now", mshr_hit, 1);
      chk("t1_noreq", l2_req_valid, 0);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("t1_hit_tbl", mshr_hit, 1);
      req("t1_rd", 3'd3, 26'h100, 2'd0);
      tick();
      chk("t1_req_done", l2_req_valid, 0);
      rsp(2'd0);
      fill("t1_fill", 4'b0010, 26'h100, 1'b0);
      tick();
      chk("t1_fill_once", fill_valid, 0);
      chk("t1_perr", protocol_err, 0);
      chk("t1_hit_gone", mshr_hit, 0);
      // dirty store miss: writeback then RWITM on the same id
      alloc(26'h3C0, 4'b0001, 1'b1, 1'b1, 26'h2A0);
      tick();
      alloc_valid = 1'b0;
      #1;
      req("t2_wb", 3'd4, 26'h2A0, 2'd0);
      tick();
      req("t2_rd", 3'd7, 26'h3C0, 2'd0);
      tick();
      chk("t2_req_done", l2_req_valid, 0);
      rsp(2'd0);
      fill("t2_fill", 4'b0001, 26'h3C0, 1'b1);
      tick();
      // backpressure
      l2_req_ready = 1'b0;
      alloc(26'h500, 4'b0100, 1'b0, 1'b0, 26'h0);
      tick();
      alloc(26'h600, 4'b1000, 1'b0, 1'b0, 26'h0);
      tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         req("t3_hold", 3'd3, 26'h500, 2'd0);
         tick();
      end
      l2_req_ready = 1'b1;
      #1;
      req("t3_hs0", 3'd3, 26'h500, 2'd0);
      tick();
      req("t3_hs1", 3'd3, 26'h600, 2'd1);
      tick();
      chk("t3_req_done", l2_req_valid, 0);
      rsp(2'd1);
      fill("t3_fill1", 4'b1000, 26'h600, 1'b0);
      rsp(2'd0);
      fill("t3_fill0", 4'b0100, 26'h500, 1'b0);
      tick();
      tick();
      // fill all four entries
      for (int i = 0; i < 4; i++) begin
         alloc(26'h1000 + 26'(i * 'h40), 4'(1 << i), 1'b0, 1'b0, 26'h0);
         chk("t4_ready", alloc_ready, 1);
         tick();
      end
      alloc(26'h7777, 4'b0001, 1'b0, 1'b0, 26'h0);
      lookup_addr = 26'h7777;
      #1;
      chk("t4_full", alloc_ready, 0);
      chk("t4_drop_hit", mshr_hit, 0);
      tick();
      alloc_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t4_no_req", l2_req_valid, 0);
      chk("t4_still_full", alloc_ready, 0);
      chk("t4_dropped", mshr_hit, 0);
      for (int i = 0; i < 4; i++) begin
         lookup_addr = 26'h1000 + 26'(i * 'h40);
         #1;
         chk("t4_hit", mshr_hit, 1);
      end
      // out-of-order responses 2,0,3,1
      rsp(2'd2);
      fill("t5_fill2", 4'b0100, 26'h1080, 1'b0);
      chk("t5_ready_fill", alloc_ready, 0);
      rsp(2'd0);
      fill("t5_fill0", 4'b0001, 26'h1000, 1'b0);
      chk("t5_ready_after", alloc_ready, 1);
      rsp(2'd3);
      fill("t5_fill3", 4'b1000, 26'h10C0, 1'b0);
      rsp(2'd1);
      fill("t5_fill1", 4'b0010, 26'h1040, 1'b0);
      chk("t5_perr_clean", protocol_err, 0);
      tick();
      rsp(2'd2);
      chk("t5_stray_fill", fill_valid, 0);
      chk("t5_perr", protocol_err, 1);
      tick();
      chk("t5_perr_sticky", protocol_err, 1);
      // reset with one entry in WAIT_FILL and another request stalled
      alloc(26'h900, 4'b0001, 1'b0, 1'b0, 26'h0);
      tick();
      alloc(26'hA00, 4'b0010, 1'b0, 1'b0, 26'h0);
      tick();
      alloc_valid = 1'b0;
      l2_req_ready = 1'b0;
      lookup_addr = 26'h900;
      #1;
      req("t6_pre", 3'd3, 26'hA00, 2'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_req", l2_req_valid, 0);
      chk("t6_op", l2_req_op, 0);
      chk("t6_addr", l2_req_addr, 0);
      chk("t6_id", l2_req_id, 0);
      chk("t6_fill", fill_valid, 0);
      chk("t6_perr", protocol_err, 0);
      chk("t6_ready", alloc_ready, 1);
      chk("t6_hit", mshr_hit, 0);
      rsp(2'd0);
      chk("t6_abandoned", protocol_err, 1);
      chk("t6_no_fill", fill_valid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
